// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch stage.
// Owns the PC, issues one outstanding request at a time to instruction memory over a req/ack
// handshake, queues returned words with their PCs in a small FIFO and presents the head to IF/ID.
// Optional performance counters are built when FETCH_PERF_EN is defined; otherwise the counter
// ports are tied to zero.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no request outstanding (buffer full, or just out of reset)
// S_REQ  | request for fetch_pc outstanding, response will be queued
// S_DROP | request outstanding for a pre-redirect address, response discarded
module pc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_fetch_pc;
  logic [31:0]        w_fetch_pc_nxt;
  logic [31:0]        r_hold_addr;
  logic [31:0]        w_hold_addr_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_after;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [31:0]        r_buf_pc   [BUF_DEPTH];
  logic [31:0]        r_buf_inst [BUF_DEPTH];
  logic               w_valid;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_target;
  logic               w_unused_tgt_lsb;

  // Only word-aligned targets are fetched; the low bits are dropped.
  assign w_target         = {branch_target_addr_i[31:2], 2'b00};
  assign w_unused_tgt_lsb = ^branch_target_addr_i[1:0];

  assign w_valid = (r_count != '0);
  // A redirect flushes the buffer, so it suppresses both the push and the pop of that cycle.
  assign w_push  = (r_state == S_REQ) && imem_ack_i && !branch_flag_i;
  assign w_pop   = w_valid && !stall && !branch_flag_i;
  assign w_count_after = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  assign imem_req_o  = (r_state != S_IDLE);
  // In DROP fetch_pc already holds the redirect target; the bus keeps the old address until ack.
  assign imem_addr_o = (r_state == S_DROP) ? r_hold_addr : r_fetch_pc;

  assign if_valid = w_valid;
  assign if_pc    = w_valid ? r_buf_pc[r_rd_ptr]   : 32'h0;
  assign if_inst  = w_valid ? r_buf_inst[r_rd_ptr] : 32'h0;

  // Next-state, next fetch PC and held bus address.
  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_hold_addr_nxt = r_hold_addr;
    case (r_state)
      S_IDLE: begin
        if (branch_flag_i) begin
          w_fetch_pc_nxt = w_target;
          w_state_nxt    = S_REQ;
        end else if (r_count < DEPTH_C) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (branch_flag_i) begin
          w_fetch_pc_nxt = w_target;
          if (!imem_ack_i) begin
            w_state_nxt     = S_DROP;
            w_hold_addr_nxt = r_fetch_pc;
          end
        end else if (imem_ack_i) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          if (w_count_after >= DEPTH_C) w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (branch_flag_i) w_fetch_pc_nxt = w_target;
        if (imem_ack_i)    w_state_nxt    = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state, PC and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_hold_addr <= RESET_PC;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_hold_addr <= w_hold_addr_nxt;
      if (branch_flag_i) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        r_count <= w_count_after;
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // FIFO storage; contents are qualified by r_count so they need no reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_buf_pc[r_wr_ptr]   <= r_fetch_pc;
      r_buf_inst[r_wr_ptr] <= imem_rdata_i;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_bubble;

  // Accepted-fetch and downstream-bubble counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch  <= 32'h0;
      r_perf_bubble <= 32'h0;
    end else begin
      if (w_push)              r_perf_fetch  <= r_perf_fetch + 32'd1;
      if (!stall && !w_valid)  r_perf_bubble <= r_perf_bubble + 32'd1;
    end
  end

  assign perf_fetch_cnt  = r_perf_fetch;
  assign perf_bubble_cnt = r_perf_bubble;
`else
  assign perf_fetch_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: zero-wait streaming, stall back-pressure, redirect during a
// delayed ack, redirect coincident with ack, PC wrap and reset during a pending request.
module tb_pc_fetch;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] TAG = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory model: the word at address A is A + TAG.
  assign imem_rdata_i = imem_addr_o + TAG;

  pc_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall                (stall),
    .branch_flag_i        (branch_flag_i),
    .branch_target_addr_i (branch_target_addr_i),
    .imem_req_o           (imem_req_o),
    .imem_addr_o          (imem_addr_o),
    .imem_ack_i           (imem_ack_i),
    .imem_rdata_i         (imem_rdata_i),
    .if_pc                (if_pc),
    .if_inst              (if_inst),
    .if_valid             (if_valid),
    .perf_fetch_cnt       (perf_fetch_cnt),
    .perf_bubble_cnt      (perf_bubble_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'h0, if_valid}, 32'h1);
    chk({tag, "_pc"},    if_pc,             pc);
    chk({tag, "_inst"},  if_inst,           pc + TAG);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_flag_i = 1'b0;
    branch_target_addr_i = 32'h0; imem_ack_i = 1'b1;

    // Reset with ack asserted: ack is ignored, outputs idle.
    step(); step();
    chk("rst_req",   {31'h0, imem_req_o}, 32'h0);
    chk("rst_valid", {31'h0, if_valid},   32'h0);
    chk("rst_pc",    if_pc,               32'h0);
    chk("rst_inst",  if_inst,             32'h0);
    chk("rst_pfetch",  perf_fetch_cnt,    32'h0);
    chk("rst_pbubble", perf_bubble_cnt,   32'h0);

    // Test 1: zero-wait memory.
    rst = 1'b0;
    step();
    chk("t1_req",   {31'h0, imem_req_o}, 32'h1);
    chk("t1_addr0", imem_addr_o,         32'h0);
    chk("t1_nv",    {31'h0, if_valid},   32'h0);
    step();
    chk_head("t1_h0", 32'h0);
    chk("t1_addr4", imem_addr_o, 32'h4);
    step();
    chk_head("t1_h4", 32'h4);
    chk("t1_addr8", imem_addr_o, 32'h8);
    step();
    chk_head("t1_h8", 32'h8);
    chk("t1_addrc", imem_addr_o, 32'hC);
    chk("t1_pfetch",  perf_fetch_cnt,  PERF ? 32'd3 : 32'd0);
    chk("t1_pbubble", perf_bubble_cnt, PERF ? 32'd2 : 32'd0);

    // Test 2: stall for 5 cycles fills the buffer and drops req.
    stall = 1'b1;
    step();
    chk("t2_req_drop", {31'h0, imem_req_o}, 32'h0);
    chk_head("t2_hold1", 32'h8);
    step(); step(); step(); step();
    chk("t2_req_low", {31'h0, imem_req_o}, 32'h0);
    chk_head("t2_hold5", 32'h8);
    stall = 1'b0;
    step();
    chk_head("t2_hc", 32'hC);
    step();
    chk("t2_empty", {31'h0, if_valid},   32'h0);
    chk("t2_req",   {31'h0, imem_req_o}, 32'h1);
    chk("t2_addr",  imem_addr_o,         32'h10);
    step();
    chk_head("t2_h10", 32'h10);
    chk("t2_addr14", imem_addr_o, 32'h14);

    // Test 3: ack delayed, redirect to 0x100 while waiting.
    imem_ack_i = 1'b0;
    step();
    chk("t3_nv1",   {31'h0, if_valid}, 32'h0);
    chk("t3_addr1", imem_addr_o,       32'h14);
    step();
    chk("t3_addr2", imem_addr_o, 32'h14);
    branch_flag_i = 1'b1; branch_target_addr_i = 32'h100;
    step();
    branch_flag_i = 1'b0;
    chk("t3_drop_addr", imem_addr_o,         32'h14);
    chk("t3_drop_req",  {31'h0, imem_req_o}, 32'h1);
    chk("t3_nv3",       {31'h0, if_valid},   32'h0);
    imem_ack_i = 1'b1;
    step();
    chk("t3_nv4",   {31'h0, if_valid}, 32'h0);
    chk("t3_tgt",   imem_addr_o,       32'h100);
    step();
    chk_head("t3_h100", 32'h100);
    chk("t3_addr104", imem_addr_o, 32'h104);

    // Test 4: misaligned target with ack in the same cycle.
    branch_flag_i = 1'b1; branch_target_addr_i = 32'h203;
    step();
    branch_flag_i = 1'b0;
    chk("t4_nv",   {31'h0, if_valid}, 32'h0);
    chk("t4_addr", imem_addr_o,       32'h200);
    step();
    chk_head("t4_h200", 32'h200);

    // Test 5: PC wrap.
    branch_flag_i = 1'b1; branch_target_addr_i = 32'hFFFF_FFFC;
    step();
    branch_flag_i = 1'b0;
    chk("t5_addr", imem_addr_o, 32'hFFFF_FFFC);
    step();
    chk_head("t5_htop", 32'hFFFF_FFFC);
    chk("t5_wrap", imem_addr_o, 32'h0);
    step();
    chk_head("t5_h0", 32'h0);

    // Test 6: reset while a request is pending and ack is high.
    rst = 1'b1;
    step();
    chk("t6_req",     {31'h0, imem_req_o}, 32'h0);
    chk("t6_valid",   {31'h0, if_valid},   32'h0);
    chk("t6_pc",      if_pc,               32'h0);
    chk("t6_pfetch",  perf_fetch_cnt,      32'h0);
    chk("t6_pbubble", perf_bubble_cnt,     32'h0);
    rst = 1'b0;
    step();
    chk("t6_req2", {31'h0, imem_req_o}, 32'h1);
    chk("t6_addr", imem_addr_o,         32'h0);
    step();
    chk_head("t6_h0", 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
